// File: rtl/mem_burst_reader_pkg.sv
// Shared types and width helpers for the burst memory reader.
package mem_reader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN
   } state_e;

   // Counter width able to hold 0..depth inclusive.
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/mem_burst_reader_if.sv
// Memory read port plus output stream of the burst reader.
interface mem_burst_reader_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
);

   logic                  rd_en;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [DATA_WIDTH-1:0] rd_data;
   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_valid;
   logic                  m_ready;
   logic                  m_last;

   modport master (
      output rd_en, rd_addr, m_data, m_valid, m_last,
      input  rd_data, m_ready
   );

   modport slave (
      input  rd_en, rd_addr, m_data, m_valid, m_last,
      output rd_data, m_ready
   );

endinterface

// File: rtl/mem_burst_reader_fifo.sv
// Return buffer: {last, data} words, flushable, push and pop in one cycle.
module mem_rd_fifo
   import mem_reader_pkg::*;
#(
   parameter  int WIDTH = 33,
   parameter  int DEPTH = 4,
   localparam int CW    = cnt_w(DEPTH),
   localparam int PW    = ptr_w(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             empty_o,
   output logic [CW-1:0]    count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_q;
   logic [PW-1:0]    rd_q;
   logic [CW-1:0]    cnt_q;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop_i && (cnt_q != '0);
   assign do_push = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (flush_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_q] <= din_i;
            wr_q        <= wr_q + PW'(1);
         end
         if (do_pop) begin
            rd_q <= rd_q + PW'(1);
         end
         cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
      end
   end

   assign dout_o  = mem_q[rd_q];
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;

endmodule

// File: rtl/mem_burst_reader.sv
// Streams a block of words from a fixed-latency RAM onto a valid/ready
// stream, single-pass or looping, with credit-limited read issue.
module mem_burst_reader
   import mem_reader_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int MEM_SIZE   = 32,
   parameter int RD_LATENCY = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   length,
   input  logic                  loop_en,
   input  logic                  abort,
   output logic                  busy,
   output logic                  done,
   mem_burst_reader_if.master    bus
);

   localparam int AW = ADDR_WIDTH;
   localparam int DW = DATA_WIDTH;
   localparam int L  = RD_LATENCY;
   localparam int CW = cnt_w(FIFO_DEPTH);

   state_e          state_q;
   logic [AW-1:0]   base_q;
   logic [AW-1:0]   cur_q;
   logic [AW:0]     len_q;
   logic [AW:0]     rem_q;
   logic            loop_q;
   logic            discard_q;
   logic            busy_q;
   logic            done_q;
   logic            rd_en_q;
   logic            rd_last_q;
   logic [AW-1:0]   rd_addr_q;
   logic [L-1:0]    pv_q;
   logic [L-1:0]    pv_d;
   logic [L-1:0]    pl_q;
   logic [L-1:0]    pl_d;
   logic [CW-1:0]   infl_q;

   logic            f_push;
   logic            f_pop;
   logic            f_flush;
   logic            f_empty;
   logic [CW-1:0]   f_count;
   logic [DW:0]     f_dout;

   logic [CW:0]     used;
   logic            issue;
   logic            last_word;
   logic            emerge;
   logic [AW-1:0]   next_addr;

   assign emerge    = pv_q[L-1];
   assign f_pop     = bus.m_valid && bus.m_ready;
   assign f_flush   = abort && (state_q != ST_IDLE);
   assign f_push    = emerge && !discard_q && !f_flush;
   assign last_word = (rem_q == (AW+1)'(1));
   assign next_addr = (cur_q == AW'(MEM_SIZE - 1)) ? '0 : cur_q + AW'(1);

   // A word leaving the buffer this cycle frees its slot for a new read.
   assign used  = {1'b0, infl_q} + {1'b0, f_count} - (CW+1)'(f_pop);
   assign issue = (state_q == ST_RUN) && !abort
                  && (used < (CW+1)'(FIFO_DEPTH));

   always_comb begin
      pv_d    = pv_q << 1;
      pv_d[0] = rd_en_q;
      pl_d    = pl_q << 1;
      pl_d[0] = rd_last_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         base_q    <= '0;
         cur_q     <= '0;
         len_q     <= '0;
         rem_q     <= '0;
         loop_q    <= 1'b0;
         discard_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         rd_en_q   <= 1'b0;
         rd_last_q <= 1'b0;
         rd_addr_q <= '0;
         pv_q      <= '0;
         pl_q      <= '0;
         infl_q    <= '0;
      end else begin
         done_q    <= 1'b0;
         rd_en_q   <= issue;
         rd_last_q <= issue && last_word;
         if (issue) begin
            rd_addr_q <= cur_q;
         end
         pv_q   <= pv_d;
         pl_q   <= pl_d;
         infl_q <= infl_q + CW'(issue) - CW'(emerge);
         unique case (state_q)
            ST_IDLE: begin
               if (start && !abort) begin
                  base_q <= base_addr;
                  len_q  <= length;
                  loop_q <= loop_en;
                  cur_q  <= base_addr;
                  rem_q  <= length;
                  if (length != '0) begin
                     state_q <= ST_RUN;
                     busy_q  <= 1'b1;
                  end else begin
                     done_q <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (abort) begin
                  state_q   <= ST_DRAIN;
                  discard_q <= 1'b1;
               end else if (issue) begin
                  if (last_word && loop_q) begin
                     cur_q <= base_q;
                     rem_q <= len_q;
                  end else if (last_word) begin
                     state_q <= ST_DRAIN;
                  end else begin
                     cur_q <= next_addr;
                     rem_q <= rem_q - (AW+1)'(1);
                  end
               end
            end
            ST_DRAIN: begin
               if (abort) begin
                  discard_q <= 1'b1;
               end
               if (infl_q == '0 && f_empty) begin
                  state_q   <= ST_IDLE;
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
                  discard_q <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   mem_rd_fifo #(
      .WIDTH (DW + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush_i (f_flush),
      .push_i  (f_push),
      .din_i   ({pl_q[L-1], bus.rd_data}),
      .pop_i   (f_pop),
      .dout_o  (f_dout),
      .empty_o (f_empty),
      .count_o (f_count)
   );

   assign busy        = busy_q;
   assign done        = done_q;
   assign bus.rd_en   = rd_en_q;
   assign bus.rd_addr = rd_addr_q;
   assign bus.m_valid = !f_empty;
   assign bus.m_data  = f_empty ? '0 : f_dout[DW-1:0];
   assign bus.m_last  = !f_empty && f_dout[DW];

endmodule

// File: tb/tb_mem_burst_reader.sv
// Directed bench for mem_burst_reader with a latency-2 RAM model.
module tb_mem_burst_reader;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int MS = 32;
   localparam int L  = 2;
   localparam int D  = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [AW:0]   length;
   logic          loop_en;
   logic          abort;
   logic          busy;
   logic          done;
   logic          m_ready;

   mem_burst_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   mem_burst_reader #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .MEM_SIZE   (MS),
      .RD_LATENCY (L),
      .FIFO_DEPTH (D)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .length    (length),
      .loop_en   (loop_en),
      .abort     (abort),
      .busy      (busy),
      .done      (done),
      .bus       (bus.master)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] mem   [MS];
   logic [DW-1:0] rpipe [L];

   always @(posedge clk) begin
      if (bus.rd_en) rpipe[0] <= mem[bus.rd_addr];
      for (int i = 1; i < L; i++) rpipe[i] <= rpipe[i-1];
   end

   assign bus.rd_data = rpipe[L-1];
   assign bus.m_ready = m_ready;

   int            checks = 0;
   int            errors = 0;
   int            rd_cnt = 0;
   int            xfer_cnt = 0;
   logic          addr_chk = 1'b1;
   logic [DW:0]   exp_q [$];
   logic [AW-1:0] addr_q [$];

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_pass(input int b, input int n);
      for (int i = 0; i < n; i++) begin
         int a;
         a = (b + i) % MS;
         exp_q.push_back({(i == n - 1), mem[a]});
         addr_q.push_back(AW'(a));
      end
   endtask

   task automatic go(input int b, input int n, input logic lp);
      base_addr = AW'(b);
      length    = (AW+1)'(n);
      loop_en   = lp;
      start     = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         tick();
         if (done) seen = 1'b1;
      end
      chk(tag, 64'(seen), 64'd1);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      tick();
      chk({tag, "_pulse"}, 64'(done), 64'd0);
   endtask

   task automatic check_reset_outs(input string tag);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_done"}, 64'(done), 64'd0);
      chk({tag, "_rd_en"}, 64'(bus.rd_en), 64'd0);
      chk({tag, "_rd_addr"}, 64'(bus.rd_addr), 64'd0);
      chk({tag, "_m_valid"}, 64'(bus.m_valid), 64'd0);
      chk({tag, "_m_last"}, 64'(bus.m_last), 64'd0);
      chk({tag, "_m_data"}, 64'(bus.m_data), 64'd0);
   endtask

   task automatic queues_empty(input string tag);
      chk({tag, "_words_left"}, 64'(exp_q.size()), 64'd0);
      chk({tag, "_addrs_left"}, 64'(addr_q.size()), 64'd0);
   endtask

   task automatic monitor();
      logic          stall;
      logic [DW-1:0] hold;
      logic [DW:0]   e;
      stall = 1'b0;
      hold  = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            stall = 1'b0;
         end else begin
            if (bus.rd_en) begin
               rd_cnt++;
               if (addr_chk) begin
                  chk("rd_pending", 64'(addr_q.size() != 0), 64'd1);
                  if (addr_q.size() != 0)
                     chk("rd_addr", 64'(bus.rd_addr), 64'(addr_q.pop_front()));
               end
            end
            if (dut.f_push && !dut.f_pop)
               chk("fifo_room", 64'(dut.f_count < 3'(D)), 64'd1);
            if (stall && bus.m_valid)
               chk("hold", 64'(bus.m_data), 64'(hold));
            if (bus.m_valid && m_ready) begin
               xfer_cnt++;
               chk("word_pending", 64'(exp_q.size() != 0), 64'd1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  chk("m_data", 64'(bus.m_data), 64'(e[DW-1:0]));
                  chk("m_last", 64'(bus.m_last), 64'(e[DW]));
               end
            end
            stall = bus.m_valid && !m_ready;
            hold  = bus.m_data;
         end
      end
   endtask

   initial begin
      int  r0;
      int  x0;
      logic hit;
      rst       = 1'b1;
      start     = 1'b0;
      abort     = 1'b0;
      loop_en   = 1'b0;
      base_addr = '0;
      length    = '0;
      m_ready   = 1'b1;
      for (int i = 0; i < MS; i++) mem[i] = DW'(i * 16);
      for (int i = 0; i < L; i++) rpipe[i] = '0;
      fork
         monitor();
      join_none

      repeat (3) @(posedge clk);
      #1;
      check_reset_outs("reset");
      rst = 1'b0;
      tick();

      // basic pass, also first-valid latency and back-to-back issue
      expect_pass(3, 5);
      go(3, 5, 1'b0);
      @(posedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("basic_rd_en", 64'(bus.rd_en), 64'd1);
         if (i == 2) chk("basic_mv_early", 64'(bus.m_valid), 64'd0);
         if (i == 3) chk("basic_mv_first", 64'(bus.m_valid), 64'd1);
      end
      @(negedge clk);
      chk("basic_rd_stop", 64'(bus.rd_en), 64'd0);
      wait_done("basic_done");
      queues_empty("basic");

      expect_pass(30, 4);
      go(30, 4, 1'b0);
      wait_done("wrap_done");
      queues_empty("wrap");

      // backpressure mid-stream
      expect_pass(8, 10);
      x0 = xfer_cnt;
      go(8, 10, 1'b0);
      hit = 1'b0;
      for (int i = 0; i < 50 && !hit; i++) begin
         tick();
         if (xfer_cnt - x0 >= 3) hit = 1'b1;
      end
      chk("bp_started", 64'(hit), 64'd1);
      m_ready = 1'b0;
      repeat (8) tick();
      chk("bp_rd_stall", 64'(bus.rd_en), 64'd0);
      chk("bp_m_valid", 64'(bus.m_valid), 64'd1);
      m_ready = 1'b1;
      wait_done("bp_done");
      queues_empty("bp");

      // loop mode, abort after seven words
      addr_chk = 1'b0;
      for (int k = 0; k < 7; k++)
         exp_q.push_back({(k % 3 == 2), mem[k % 3]});
      x0 = xfer_cnt;
      go(0, 3, 1'b1);
      hit = 1'b0;
      for (int i = 0; i < 100 && !hit; i++) begin
         tick();
         if (xfer_cnt - x0 == 7) hit = 1'b1;
      end
      chk("loop_seven", 64'(hit), 64'd1);
      abort   = 1'b1;
      m_ready = 1'b0;
      tick();
      abort = 1'b0;
      chk("abort_m_valid", 64'(bus.m_valid), 64'd0);
      m_ready = 1'b1;
      wait_done("abort_done");
      chk("loop_words_left", 64'(exp_q.size()), 64'd0);
      addr_chk = 1'b1;

      r0 = rd_cnt;
      go(7, 0, 1'b0);
      chk("len0_done", 64'(done), 64'd1);
      chk("len0_busy", 64'(busy), 64'd0);
      tick();
      chk("len0_pulse", 64'(done), 64'd0);
      repeat (4) tick();
      chk("len0_no_rd", 64'(rd_cnt - r0), 64'd0);

      expect_pass(0, 4);
      r0 = rd_cnt;
      go(0, 4, 1'b0);
      tick();
      base_addr = 5'd20;
      length    = 6'd2;
      start     = 1'b1;
      tick();
      start = 1'b0;
      wait_done("runstart_done");
      chk("runstart_rd", 64'(rd_cnt - r0), 64'd4);
      queues_empty("runstart");

      r0 = rd_cnt;
      base_addr = '0;
      length    = 6'd3;
      start     = 1'b1;
      abort     = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      chk("sa_busy", 64'(busy), 64'd0);
      repeat (3) tick();
      chk("sa_done", 64'(done), 64'd0);
      chk("sa_no_rd", 64'(rd_cnt - r0), 64'd0);

      // asynchronous reset in the middle of a stalled run
      addr_chk = 1'b0;
      m_ready  = 1'b0;
      go(0, 10, 1'b0);
      repeat (6) tick();
      chk("rst_pre_busy", 64'(busy), 64'd1);
      #3;
      rst = 1'b1;
      #1;
      check_reset_outs("midrst");
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      addr_q.delete();
      m_ready  = 1'b1;
      addr_chk = 1'b1;
      tick();
      expect_pass(5, 3);
      go(5, 3, 1'b0);
      wait_done("post_rst_done");
      queues_empty("post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_burst_reader.md
Name: mem_burst_reader

Overview:
- Parametrised successor to the single-address memory reader.
- Streams a programmable block of words (base address, length) out of a synchronous RAM with configurable read latency. Supports single-pass or looping mode.
- Output is a valid/ready stream with backpressure; an internal credit-limited FIFO absorbs in-flight read returns.
- Sits between a memory bank and the dot-product datapath/FIFO stage; started and monitored by the control FSM.

Parameters:
- DATA_WIDTH, 32, memory word width.
- ADDR_WIDTH, 5, memory address width.
- MEM_SIZE, 32, number of words; addresses wrap from MEM_SIZE-1 to 0. Must be ≤ 2^ADDR_WIDTH.
- RD_LATENCY, 1, cycles from rd_en to valid rd_data. Must be ≥ 1.
- FIFO_DEPTH, 4, output buffer depth. Must be ≥ RD_LATENCY+1 and a power of 2.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; accepted only in IDLE.
- base_addr  in  ADDR_WIDTH  first address; sampled on accepted start.
- length  in  ADDR_WIDTH+1  words per pass; sampled on accepted start.
- loop_en  in  1  1 = repeat passes until abort; sampled on accepted start.
- abort  in  1  one-cycle pulse; stops the transfer.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse on return to IDLE.
- rd_en  out  1  memory read strobe.
- rd_addr  out  ADDR_WIDTH  memory read address.
- rd_data  in  DATA_WIDTH  memory data, valid RD_LATENCY cycles after rd_en.
- m_data  out  DATA_WIDTH  stream data.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.
- m_last  out  1  marks the final word of each pass.

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, rd_en=0, rd_addr=0, m_valid=0, m_last=0, m_data=0. FIFO, latency pipe and all counters cleared. Reset mid-transfer discards everything.
- States:
  - IDLE: on start, if length≠0 → RUN; cur_addr=base_addr, remaining=length.
  - IDLE: on start with length=0 → IDLE, done=1 next cycle, no reads issued.
  - RUN: issues reads. When the last word of a pass is issued with loop_en=0 → DRAIN. With loop_en=1, reload cur_addr=base_addr and remaining=length, and stay in RUN.
  - DRAIN: no issue. When latency pipe and FIFO are both empty → IDLE with done=1 for one cycle.
- Issue rule: rd_en=1 in a cycle iff state=RUN and in_flight + fifo_count < FIFO_DEPTH.
  - rd_en and rd_addr are registered outputs. in_flight counts issued reads whose data has not yet returned.
  - Each issue advances cur_addr by 1 modulo MEM_SIZE and decrements remaining.
- Return path: a RD_LATENCY-deep shift register carries {valid, last} alongside each read. When it emerges, rd_data and the last flag are written to the FIFO. Overflow is impossible by the credit rule; verification asserts this.
- Stream: m_valid = FIFO not empty; m_data/m_last = FIFO head. A word transfers when m_valid && m_ready. m_data holds stable while m_valid=1 && m_ready=0. A FIFO push and pop in the same cycle are both honoured.
- m_last=1 on the word corresponding to the last address of each pass, including every pass in loop mode.
- Abort (RUN or DRAIN):
  - Issue stops the same cycle.
  - FIFO is flushed; m_valid=0 from the next cycle.
  - In-flight returns are discarded.
  - State → DRAIN; done pulses when the pipe is empty.
  - Abort in IDLE is ignored. Abort simultaneous with start in IDLE: abort wins, start is ignored.
- start while busy: ignored, no effect on parameters.
- Throughput: with m_ready held high, one word per cycle sustained. First m_valid appears RD_LATENCY+2 cycles after start: 1 cycle to register rd_en, RD_LATENCY in memory, 1 cycle FIFO write.

Decomposition:
- Package mem_reader_pkg: state encoding (IDLE, RUN, DRAIN) and width helper functions (clog2 for FIFO count).
- Sub-module mem_rd_fifo: synchronous FIFO, DATA_WIDTH+1 wide (data + last), FIFO_DEPTH deep, with count, flush input and async active-high reset.

Test Plan:
- Basic pass: base=3, length=5, loop_en=0, m_ready=1, mem[i]=i*16 → rd_addr 3..7 on consecutive cycles. m_data 0x30,0x40,0x50,0x60,0x70 with m_last on 0x70. One done pulse, then busy=0.
- Address wrap: base=30, length=4, MEM_SIZE=32 → rd_addr 30,31,0,1. Output order matches.
- Backpressure: RD_LATENCY=2, FIFO_DEPTH=4, length=10, m_ready low for 8 cycles mid-stream → rd_en stalls once in_flight+count=4. No data lost or duplicated; m_data stable while stalled; all 10 words delivered in order.
- Loop mode: base=0, length=3, loop_en=1, then abort after 7 transferred words → sequence 0,1,2,0,1,2,0 with m_last on every third word. After abort, m_valid=0 next cycle and done pulses once the pipe is empty.
- Edge cases: length=0 start → done pulse, no rd_en. start pulsed during RUN → ignored. start+abort together in IDLE → stays IDLE.
- Reset mid-RUN: assert rst asynchronously between clock edges → all outputs 0 immediately. A new start after release works from a clean state.
